// File: rtl/reg1.sv
// Single-bit register cell: load mux + master/slave latch pair, async active-low reset and preset, true and complement outputs.
// Latency: Q takes D on the same rising edge of C that samples L=1; reset/preset act immediately without a clock.
// Backpressure: none; L=0 simply holds the stored bit.
module reg1 (
  input  logic C,
  input  logic nR,
  input  logic nP,
  input  logic D,
  input  logic L,
  output logic Q,
  output logic Qbar
);

  logic m_dat;
  logic m_ld;
  logic s_q;

  // Master latch is transparent while C is low. It carries D and L separately,
  // so the load mux is resolved at the slave and the cell has no latch-to-latch loop.
  // While reset or preset is asserted the master is parked in hold mode, so
  // releasing either control with C high cannot trigger a capture.
  always_latch begin
    if (!nR || !nP) begin
      m_dat <= 1'b0;
      m_ld  <= 1'b0;
    end else if (!C) begin
      m_dat <= D;
      m_ld  <= L;
    end
  end

  // Slave latch is transparent while C is high. Reset dominates preset.
  // Level-sensitive controls let Q go to 1 as soon as nR releases under a held nP.
  always_latch begin
    if (!nR) begin
      s_q <= 1'b0;
    end else if (!nP) begin
      s_q <= 1'b1;
    end else if (C && m_ld) begin
      s_q <= m_dat;
    end
  end

  assign Q    = s_q;
  assign Qbar = ~s_q;

endmodule

// File: tb/tb_reg1.sv
// Directed bench for reg1: a rule-level model of the cell is checked after every step, plus literal expectations.
module tb_reg1;

  logic C, nR, nP, D, L;
  logic Q, Qbar;

  reg1 dut (
    .C    (C),
    .nR   (nR),
    .nP   (nP),
    .D    (D),
    .L    (L),
    .Q    (Q),
    .Qbar (Qbar)
  );

  int   errors = 0;
  int   checks = 0;
  logic mq     = 1'b0;
  bit   mvalid = 1'b0;
  event smp;

  // Apply one input vector, then update the model from the cell's rules:
  // reset beats preset, preset beats clock, a 0->1 edge of C with L=1 loads the pre-edge D.
  task automatic step(input logic c, input logic r, input logic p, input logic d, input logic l);
    logic pc, pd, pl;
    pc = C;
    pd = D;
    pl = L;
    C  = c;
    nR = r;
    nP = p;
    D  = d;
    L  = l;
    #1;
    if (!r) begin
      mq = 1'b0;
      mvalid = 1'b1;
    end else if (!p) begin
      mq = 1'b1;
      mvalid = 1'b1;
    end else if (!pc && c && pl) begin
      mq = pd;
    end
    #1;
    -> smp;
    #1;
  endtask

  always @(smp) begin
    if (mvalid) begin
      checks = checks + 1;
      if (Q !== mq) begin
        errors = errors + 1;
        $display("FAIL model_q t=%0t: Q=%b required %b", $time, Q, mq);
      end
      checks = checks + 1;
      if (Qbar !== ~mq) begin
        errors = errors + 1;
        $display("FAIL model_qbar t=%0t: Qbar=%b required %b", $time, Qbar, ~mq);
      end
    end
  end

  task automatic lit(input string name, input logic eq, input logic eqb);
    checks = checks + 1;
    if (Q !== eq || Qbar !== eqb) begin
      errors = errors + 1;
      $display("FAIL %s: Q=%b Qbar=%b required Q=%b Qbar=%b", name, Q, Qbar, eq, eqb);
    end
  endtask

  initial begin
    C  = 1'b0;
    nR = 1'b1;
    nP = 1'b1;
    D  = 1'b0;
    L  = 1'b0;
    #5;

    // Preset then reset, no clock edges.
    step(0, 1, 0, 0, 1);  lit("preset", 1'b1, 1'b0);
    step(0, 0, 1, 0, 1);  lit("reset_async", 1'b0, 1'b1);

    // Load 1.
    step(0, 1, 1, 1, 1);  lit("load1_before_edge", 1'b0, 1'b1);
    step(1, 1, 1, 1, 1);  lit("load1_edge", 1'b1, 1'b0);

    // Load 0, then D toggles while C is high.
    step(0, 1, 1, 0, 1);  lit("load0_before_edge", 1'b1, 1'b0);
    step(1, 1, 1, 0, 1);  lit("load0_edge", 1'b0, 1'b1);
    step(1, 1, 1, 1, 1);  lit("d_toggle_c_high", 1'b0, 1'b1);
    step(1, 1, 1, 0, 1);

    // Hold with L=0 from Q=0.
    step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);  lit("hold0_d1", 1'b0, 1'b1);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);  lit("hold0_d0", 1'b0, 1'b1);

    // Hold with L=0 from Q=1.
    step(0, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);  lit("reload1", 1'b1, 1'b0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);  lit("hold1_d0", 1'b1, 1'b0);

    // L raised while C high, then a falling edge: nothing captured.
    step(1, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);  lit("falling_edge", 1'b1, 1'b0);

    // Both controls asserted: reset wins, clock ignored; releasing nR alone presets at once.
    step(0, 0, 0, 0, 1);  lit("both_asserted", 1'b0, 1'b1);
    step(1, 0, 0, 1, 1);  lit("both_clk_ignored", 1'b0, 1'b1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 1);  lit("release_nr_only", 1'b1, 1'b0);
    step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);  lit("preset_clk_ignored", 1'b1, 1'b0);
    step(1, 1, 1, 0, 1);  lit("release_np_c_high", 1'b1, 1'b0);

    // Reset while C=1, D=1, L=1; release with C high: held until the next rising edge.
    step(0, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    step(1, 0, 1, 1, 1);  lit("reset_c_high", 1'b0, 1'b1);
    step(1, 1, 1, 1, 1);  lit("release_nr_c_high", 1'b0, 1'b1);
    step(0, 1, 1, 1, 1);  lit("after_release_low", 1'b0, 1'b1);
    step(1, 1, 1, 1, 1);  lit("next_edge_captures", 1'b1, 1'b0);

    // Reset coincident with a rising edge that would load 1 from Q=0.
    step(0, 1, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    step(1, 0, 1, 1, 1);  lit("reset_on_edge", 1'b0, 1'b1);
    step(1, 1, 1, 1, 1);  lit("reset_on_edge_release", 1'b0, 1'b1);
    step(0, 1, 1, 1, 1);

    // Directed D/L pattern over several clock cycles, model-checked each step.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      step(0, 1, 1, iv[0] ^ iv[2], iv[1] | iv[3]);
      step(1, 1, 1, iv[0] ^ iv[2], iv[1] | iv[3]);
    end

    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
